pll_lock_sequencer: RTL and testbench
=====================================

# pll_lock_sequencer

Consumes the free-running 57.272720 MHz PLL output clock and the PLL's asynchronous `locked` flag. Produces a clean, synchronous, active-high system reset and phase-aligned clock enables at 28.636360, 14.318180 and 7.159090 MHz, so downstream video/CPU logic runs on one clock with enables instead of multiple PLL outputs. Sits directly after the PLL wrapper in the board top level. It also counts lock-loss events for the OSD/debug readout.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flop depth of the `pll_locked` synchronizer (≥2).
- `FILTER_CYCLES`, 16: consecutive synchronized-locked cycles required before reset hold begins (≥1).
- `RST_HOLD`, 1024: cycles `sys_rst` stays high after filtering. Must be a nonzero multiple of 8.

Ports:
- `clk`  in  1  57.272720 MHz PLL clock (outclk_3); all logic on rising edge.
- `rst`  in  1  reset: synchronous, active-high; forces all state to reset values.
- `pll_locked`  in  1  PLL lock flag, asynchronous to `clk`.
- `sys_rst`  out  1  system reset, synchronous, active-high.
- `ce_28m`  out  1  one-cycle enable every 2 clk.
- `ce_14m`  out  1  one-cycle enable every 4 clk.
- `ce_7m`  out  1  one-cycle enable every 8 clk.
- `running`  out  1  high when state is RUN.
- `lock_drops`  out  8  saturating count of lock losses while in RUN.

## Operation
- `pll_locked` passes through a `SYNC_STAGES` flop chain to give `lk_s`. There is no other use of the raw input.
- `cnt`: a counter of width clog2(max(FILTER_CYCLES, RST_HOLD)) + 1.
- `div`: a 3-bit wrapping counter.
- State machine states are WAIT, FILTER, HOLD and RUN; reset state is WAIT.
  - WAIT: if `lk_s`, go to FILTER with cnt←0.
  - FILTER: if !`lk_s`, go to WAIT. Otherwise cnt←cnt+1; when cnt==FILTER_CYCLES−1, go to HOLD with cnt←0 and div←0.
  - HOLD: if !`lk_s`, go to WAIT. Otherwise cnt←cnt+1 and div←div+1; when cnt==RST_HOLD−1, go to RUN.
  - RUN: div←div+1. If !`lk_s`, go to WAIT and lock_drops←min(lock_drops+1, 255).
- `div` increments only in HOLD and RUN. It holds its value in WAIT and FILTER.
- Because RST_HOLD is a multiple of 8, div==0 on the first RUN cycle.
- Clock enables are a combinational decode of the registered `div` and state, and are valid only in HOLD or RUN (0 otherwise):
  - ce_28m = div[0]
  - ce_14m = div[1:0]==3
  - ce_7m = div==7
- `sys_rst` = (state != RUN), registered form of state (no extra delay beyond the state register).
- `running` = (state == RUN).
- Lock loss in WAIT, FILTER or HOLD does not increment `lock_drops`.
- `rst` has priority over everything. Asserting it mid-RUN returns to WAIT and clears `lock_drops` on the next edge.

## Timing
- Reset values (the cycle after `rst` is sampled high):
  - `sys_rst`=1
  - `ce_*`=0
  - `running`=0
  - `lock_drops`=0
  - div=0, cnt=0, synchronizer flops=0
- Lock-to-release latency is counted from the edge `pll_locked` rises: SYNC_STAGES + 1 + FILTER_CYCLES + RST_HOLD cycles until `sys_rst` is low. With defaults: 2+1+16+1024 = 1043.
- Lock-loss latency: `sys_rst` is high SYNC_STAGES+1 edges after `pll_locked` falls, and the `ce_*` outputs go low in the same cycle.
- The enables keep fixed phase across the HOLD→RUN boundary. The first RUN cycle has div==0, so ce_28m=0; ce_28m=1 next cycle; ce_7m=1 on the 8th RUN cycle.
- A `pll_locked` glitch shorter than FILTER_CYCLES during FILTER restarts filtering and never releases reset.
- lock_drops at 255 stays 255.

## Test plan
- Reset then lock: hold `rst` for 3 cycles, raise `pll_locked` at cycle 10 → `sys_rst` falls exactly 1043 edges later, `running`=1, and `div` reads 0 on that cycle.
- Enable cadence in RUN: over 64 cycles → ce_28m pulses 32 times, ce_14m 16 times, ce_7m 8 times. ce_7m coincides with ce_14m and ce_28m, and all three are high only when div==7.
- Glitch rejection: pulse `pll_locked` high for 10 cycles, low for 5, then hold high → `sys_rst` falls 1043 edges after the final rise. No HOLD entry occurs from the 10-cycle pulse.
- Lock loss in RUN: drop `pll_locked` → `sys_rst`=1 three edges later, all `ce_*`=0, `lock_drops` increments 0→1. On relock, release takes 1043 cycles.
- Saturation: 260 RUN-state lock drops using FILTER_CYCLES=1 and RST_HOLD=8 → `lock_drops` ends at 255.
- Reset mid-HOLD and mid-RUN: assert `rst` for 1 cycle → next edge `sys_rst`=1, `lock_drops`=0, state WAIT. Sequencing restarts from full latency.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// Purpose : turns the free-running PLL clock plus its async lock flag into a clean
//           synchronous system reset and phase-aligned 1/2, 1/4, 1/8 clock enables.
// Latency : release SYNC_STAGES+1+FILTER_CYCLES+RST_HOLD edges after lock rises;
//           reset re-asserts SYNC_STAGES+1 edges after lock falls.
// Backpressure: none; free-running, no handshake.
//
// Ports:
//   clk         PLL output clock, all logic on the rising edge
//   rst         synchronous active-high reset, highest priority
//   pll_locked  raw PLL lock flag, asynchronous to clk
//   sys_rst     synchronous active-high system reset (high unless in RUN)
//   ce_28m      enable every 2nd clk (HOLD/RUN only)
//   ce_14m      enable every 4th clk (HOLD/RUN only)
//   ce_7m       enable every 8th clk (HOLD/RUN only)
//   running     high while in RUN
//   lock_drops  saturating count of lock losses seen while in RUN
module pll_lock_sequencer #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 16,
  parameter int RST_HOLD      = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       sys_rst,
  output logic       ce_28m,
  output logic       ce_14m,
  output logic       ce_7m,
  output logic       running,
  output logic [7:0] lock_drops
);

  localparam int MAX_CNT = (FILTER_CYCLES > RST_HOLD) ? FILTER_CYCLES : RST_HOLD;
  localparam int CW      = $clog2(MAX_CNT) + 1;

  localparam logic [CW-1:0] FILTER_LAST = CW'(FILTER_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(RST_HOLD - 1);

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_FILTER = 2'd1,
    ST_HOLD   = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic [2:0]             r_div;
  logic [7:0]             r_drops;

  state_t                 w_state_nxt;
  logic [CW-1:0]          w_cnt_nxt;
  logic [2:0]             w_div_nxt;
  logic [7:0]             w_drops_nxt;
  logic                   w_lk_s;
  logic                   w_ce_ok;

  // Last flop of the synchronizer chain is the only view of the lock flag.
  assign w_lk_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= '0;
      r_state <= ST_WAIT;
      r_cnt   <= '0;
      r_div   <= '0;
      r_drops <= '0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], pll_locked};
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_div   <= w_div_nxt;
      r_drops <= w_drops_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_div_nxt   = r_div;
    w_drops_nxt = r_drops;
    case (r_state)
      ST_WAIT: begin
        if (w_lk_s) begin
          w_state_nxt = ST_FILTER;
          w_cnt_nxt   = '0;
        end
      end
      ST_FILTER: begin
        if (!w_lk_s) begin
          w_state_nxt = ST_WAIT;
        end else if (r_cnt == FILTER_LAST) begin
          // Divider restarts here so it wraps to 0 exactly on the first RUN
          // cycle (RST_HOLD is a multiple of 8), keeping enable phase fixed.
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = '0;
          w_div_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_HOLD: begin
        if (!w_lk_s) begin
          w_state_nxt = ST_WAIT;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
          w_div_nxt = r_div + 1'b1;
          if (r_cnt == HOLD_LAST) begin
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        w_div_nxt = r_div + 1'b1;
        if (!w_lk_s) begin
          w_state_nxt = ST_WAIT;
          if (r_drops != 8'hFF) begin
            w_drops_nxt = r_drops + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_WAIT;
      end
    endcase
  end

  // Enables are decoded straight from registered state/divider: no extra delay.
  assign w_ce_ok    = (r_state == ST_HOLD) || (r_state == ST_RUN);
  assign ce_28m     = w_ce_ok && r_div[0];
  assign ce_14m     = w_ce_ok && (r_div[1:0] == 2'b11);
  assign ce_7m      = w_ce_ok && (r_div == 3'b111);
  assign sys_rst    = (r_state != ST_RUN);
  assign running    = (r_state == ST_RUN);
  assign lock_drops = r_drops;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Purpose : directed self-checking bench for pll_lock_sequencer (default and
//           short-sequence parameterisations).
// Latency/backpressure: not applicable; inputs driven and outputs sampled 1 unit after posedge.
module tb_pll_lock_sequencer;

  logic       clk;
  logic       rst;
  logic       pll_locked;
  logic       sys_rst;
  logic       ce_28m;
  logic       ce_14m;
  logic       ce_7m;
  logic       running;
  logic [7:0] lock_drops;

  logic       rst2;
  logic       pll_locked2;
  logic       sys_rst2;
  logic       ce_28m2;
  logic       ce_14m2;
  logic       ce_7m2;
  logic       running2;
  logic [7:0] lock_drops2;

  int n_checks;
  int n_fail;

  pll_lock_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .sys_rst    (sys_rst),
    .ce_28m     (ce_28m),
    .ce_14m     (ce_14m),
    .ce_7m      (ce_7m),
    .running    (running),
    .lock_drops (lock_drops)
  );

  pll_lock_sequencer #(
    .SYNC_STAGES   (2),
    .FILTER_CYCLES (1),
    .RST_HOLD      (8)
  ) dut_sat (
    .clk        (clk),
    .rst        (rst2),
    .pll_locked (pll_locked2),
    .sys_rst    (sys_rst2),
    .ce_28m     (ce_28m2),
    .ce_14m     (ce_14m2),
    .ce_7m      (ce_7m2),
    .running    (running2),
    .lock_drops (lock_drops2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [2:0] ce_v;
  logic [2:0] exp_v;
  logic [2:0] d;
  int         c28, c14, c7;
  logic       any_ce;
  logic       bad_rst;
  int         t;

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    pll_locked  = 1'b0;
    rst2        = 1'b1;
    pll_locked2 = 1'b0;

    // Reset then lock
    tick(3);
    rst = 1'b0;
    chk("rst_sys_rst", sys_rst, 1);
    chk("rst_ce", {ce_7m, ce_14m, ce_28m}, 0);
    chk("rst_running", running, 0);
    chk("rst_drops", lock_drops, 0);
    tick(7);
    chk("nolock_sys_rst", sys_rst, 1);
    pll_locked = 1'b1;
    tick(1042);
    chk("lock_pre_release", sys_rst, 1);
    tick(1);
    chk("lock_release", sys_rst, 0);
    chk("lock_running", running, 1);
    chk("lock_div0", dut.r_div, 0);
    chk("lock_first_ce", {ce_7m, ce_14m, ce_28m}, 0);

    // Enable cadence over 64 RUN cycles
    c28 = 0; c14 = 0; c7 = 0;
    d = 3'd0;
    for (int i = 0; i < 64; i++) begin
      ce_v  = {ce_7m, ce_14m, ce_28m};
      exp_v = {d == 3'd7, d[1:0] == 2'b11, d[0]};
      chk("cadence_ce", ce_v, exp_v);
      c28 += ce_28m;
      c14 += ce_14m;
      c7  += ce_7m;
      tick(1);
      d = d + 3'd1;
    end
    chk("cnt_28m", c28, 32);
    chk("cnt_14m", c14, 16);
    chk("cnt_7m", c7, 8);
    chk("cadence_running", running, 1);

    // Lock loss in RUN
    pll_locked = 1'b0;
    tick(2);
    chk("loss_2edges_sys_rst", sys_rst, 0);
    tick(1);
    chk("loss_sys_rst", sys_rst, 1);
    chk("loss_ce", {ce_7m, ce_14m, ce_28m}, 0);
    chk("loss_running", running, 0);
    chk("loss_drops", lock_drops, 1);
    pll_locked = 1'b1;
    tick(1042);
    chk("relock_pre_release", sys_rst, 1);
    tick(1);
    chk("relock_release", sys_rst, 0);
    chk("relock_drops", lock_drops, 1);

    // Second drop, then glitch rejection from WAIT
    pll_locked = 1'b0;
    tick(8);
    chk("drop2_drops", lock_drops, 2);
    any_ce  = 1'b0;
    bad_rst = 1'b0;
    pll_locked = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      any_ce  |= ce_28m | ce_14m | ce_7m;
      bad_rst |= ~sys_rst;
    end
    pll_locked = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      any_ce  |= ce_28m | ce_14m | ce_7m;
      bad_rst |= ~sys_rst;
    end
    pll_locked = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      any_ce  |= ce_28m | ce_14m | ce_7m;
      bad_rst |= ~sys_rst;
    end
    chk("glitch_no_hold_ce", any_ce, 0);
    chk("glitch_no_release", bad_rst, 0);
    tick(1032);
    chk("glitch_pre_release", sys_rst, 1);
    tick(1);
    chk("glitch_release", sys_rst, 0);
    chk("glitch_drops", lock_drops, 2);

    // Reset mid-RUN
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rstrun_sys_rst", sys_rst, 1);
    chk("rstrun_drops", lock_drops, 0);
    chk("rstrun_running", running, 0);
    chk("rstrun_ce", {ce_7m, ce_14m, ce_28m}, 0);
    tick(1042);
    chk("rstrun_pre_release", sys_rst, 1);
    tick(1);
    chk("rstrun_release", sys_rst, 0);

    // Reset mid-HOLD
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(500);
    chk("hold_sys_rst", sys_rst, 1);
    any_ce = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      any_ce |= ce_28m;
    end
    chk("hold_ce_active", any_ce, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rsthold_sys_rst", sys_rst, 1);
    chk("rsthold_ce", {ce_7m, ce_14m, ce_28m}, 0);
    chk("rsthold_drops", lock_drops, 0);
    tick(1042);
    chk("rsthold_pre_release", sys_rst, 1);
    tick(1);
    chk("rsthold_release", sys_rst, 0);

    // Saturation on the short-sequence instance
    rst2 = 1'b0;
    tick(1);
    chk("sat_rst_drops", lock_drops2, 0);
    for (int i = 0; i < 260; i++) begin
      pll_locked2 = 1'b1;
      t = 0;
      while (!running2 && t < 100) begin
        tick(1);
        t++;
      end
      chk("sat_run", running2, 1);
      pll_locked2 = 1'b0;
      t = 0;
      while (running2 && t < 100) begin
        tick(1);
        t++;
      end
      chk("sat_drop", running2, 0);
      chk("sat_count", lock_drops2, (i + 1 > 255) ? 255 : i + 1);
    end
    chk("sat_final", lock_drops2, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
